fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage, directly upstream of `decode_stage`. Holds the program counter, issues one lookup per cycle to the instruction cache and waits out misses. Applies taken-branch redirects from execute. Drives the fetch/decode pipeline register: instruction word, `PCNEXT`, valid.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `clk` in 1: single clock, all state updates on rising edge.
- `reset` in 1: synchronous, active-high; clears all state.
- `EN_REG` in 1: stage-register enable from `control` (its `EN_REG_FETCH`); 0 = hold PC and outputs.
- `branch_taken` in 1: redirect request from execute.
- `branch_target` in 32: redirect address; bits [1:0] ignored (forced 0).
- `icache_hit` in 1: same-cycle hit for `icache_addr`.
- `icache_data` in 32: instruction word; valid when `icache_hit`=1.
- `icache_fill_done` in 1: one-cycle pulse, line fill for the missed address complete.
- `icache_req` out 1: lookup request, combinational.
- `icache_addr` out 32: lookup address (current PC), combinational.
- `instruction` out 32: registered instruction to decode.
- `PCNEXT` out 32: registered PC+4 of that instruction.
- `instr_valid` out 1: registered; 0 = bubble.
- `flush` out 1: registered; 1 for the cycle after a redirect is accepted, drives decode `flush`.
- `block_pipe_instr_cache` out 1: miss stall to `control`, combinational.

## Operation
- FSM states: FETCH, MISS_WAIT.
- Reset:
  - PC = `RESET_PC`; state FETCH; `redir_pend` = 0.
  - `instruction` = NOP_INSTR (32'h0); `PCNEXT` = 0; `instr_valid` = 0; `flush` = 0.
- `icache_req` = 1 in FETCH, 0 in MISS_WAIT. `icache_addr` = PC.
- FETCH, hit, `EN_REG`=1: `instruction` ← `icache_data`; `PCNEXT` ← PC+4; `instr_valid` ← 1; PC ← PC+4.
- FETCH, hit, `EN_REG`=0: hold PC and all outputs. The same address is re-looked-up next cycle.
- FETCH, miss (`icache_hit`=0): go to MISS_WAIT; PC unchanged.
- MISS_WAIT:
  - Each cycle with `EN_REG`=1, output register ← NOP bubble (`instr_valid`=0).
  - On `icache_fill_done`, return to FETCH. With no pending redirect, the same PC is re-issued and hits.
- `block_pipe_instr_cache` = (FETCH & !`icache_hit`) | MISS_WAIT.
- Redirect (`branch_taken`=1) is accepted in any cycle, independent of `EN_REG`:
  - In FETCH: PC ← target; output register ← NOP bubble; `flush` ← 1. The wrong-path hit in that cycle is discarded.
  - In MISS_WAIT: the in-flight fill cannot be aborted. Latch target into `redir_tgt` and set `redir_pend`; output ← bubble; `flush` ← 1. On `icache_fill_done`: PC ← `redir_tgt`, clear `redir_pend`, go to FETCH.
  - A second redirect while `redir_pend`=1 overwrites `redir_tgt`; the latest one wins.
- Priority: reset > redirect > `EN_REG` hold > normal advance.
- Arithmetic: PC+4 is 32-bit modulo; 32'hFFFF_FFFC+4 = 0, with no flag.
- Reset mid-miss: return to FETCH at `RESET_PC` and drop the pending redirect. Any `icache_fill_done` arriving afterwards is ignored.

## Timing
- Hit latency: 1 cycle. The instruction whose lookup hits in cycle N is on `instruction` in N+1.
- Throughput: one instruction per cycle while hitting and `EN_REG`=1.
- Miss: `block_pipe_instr_cache` is high from the detect cycle through the `icache_fill_done` cycle inclusive. The re-issue hits the cycle after fill done, and the instruction appears 1 cycle later.
- Redirect:
  - In FETCH: `branch_taken` in N → `flush`=1 and bubble in N+1; `icache_addr` = target in N+1; target instruction on output in N+2 on a hit.
  - In MISS_WAIT: `flush` is still 1 in the next cycle; fetch of the target starts the cycle after fill done.
- `flush` is a single-cycle pulse per accepted redirect.

## Structure
- Package `fetch_pkg`: `fetch_state_t` enum {FETCH, MISS_WAIT}; `NOP_INSTR` = 32'h0; `INSTR_BYTES` = 4.
- Sub-module `pc_unit`: PC register, next-PC mux (hold / +4 / target / pending target), pending-redirect register.
- Top module holds the FSM and the output stage register.

## Test plan
- Reset, `RESET_PC`=32'h100, `icache_hit` always 1 → addresses 0x100, 0x104, 0x108 in consecutive cycles; `PCNEXT` 0x104, 0x108, 0x10C one cycle later; `instr_valid`=1.
- Miss at 0x104, `icache_fill_done` 3 cycles later → `block_pipe_instr_cache` high 4 cycles; 4 bubbles; 0x104 re-issued; its instruction output with `PCNEXT`=0x108.
- `branch_taken` with target 0x203 at PC 0x10C → `flush` pulse 1 cycle; next `icache_addr`=0x200; 0x10C instruction never marked valid.
- Redirect to 0x400 during MISS_WAIT, then a second redirect to 0x500 before fill done → after fill, fetch at 0x500; `flush` pulses twice.
- `EN_REG`=0 for 2 cycles while hitting → PC and outputs frozen; resume with no skipped or duplicated instruction. PC=0xFFFFFFFC hit → `PCNEXT`=0, next fetch at 0.
- `reset` asserted during MISS_WAIT with a redirect pending → all outputs at reset values next cycle; fetch resumes at `RESET_PC`; a late `icache_fill_done` is ignored.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

   // Fetch controller states
   typedef enum logic [0:0] {
      FETCH     = 1'b0,
      MISS_WAIT = 1'b1
   } fetch_state_t;

   // Next-PC source selection
   typedef enum logic [1:0] {
      PC_HOLD   = 2'd0,
      PC_INC    = 2'd1,
      PC_TARGET = 2'd2,
      PC_PEND   = 2'd3
   } pc_sel_t;

   // Fetch/decode register update selection
   typedef enum logic [1:0] {
      OUT_HOLD   = 2'd0,
      OUT_LOAD   = 2'd1,
      OUT_BUBBLE = 2'd2
   } out_sel_t;

   localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;
   localparam logic [31:0] INSTR_BYTES = 32'd4;

   // Instructions are word aligned: the two low address bits never reach the PC
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-cache lookup bus between the fetch stage (master) and the cache (slave).
interface fetch_stage_if;
   logic        icache_req;
   logic [31:0] icache_addr;
   logic        icache_hit;
   logic [31:0] icache_data;
   logic        icache_fill_done;

   modport master (
      output icache_req,
      output icache_addr,
      input  icache_hit,
      input  icache_data,
      input  icache_fill_done
   );

   modport slave (
      input  icache_req,
      input  icache_addr,
      output icache_hit,
      output icache_data,
      output icache_fill_done
   );
endinterface

// File: rtl/pc_unit.sv
// Program counter, next-PC mux and the redirect that waits out an in-flight cache fill.
module pc_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  pc_sel_t     pc_sel,
   input  logic [31:0] branch_target,
   input  logic        latch_redir,
   input  logic        clr_pend,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        redir_pend
);

   logic [31:0] redir_tgt;

   // PC+4 wraps modulo 2^32 without any flag
   assign pc_plus4 = pc + INSTR_BYTES;

   // PC register: hold, advance, take a live redirect, or take the parked one
   always_ff @(posedge clk) begin
      if (reset) begin
         pc <= RESET_PC;
      end else begin
         case (pc_sel)
            PC_HOLD:   pc <= pc;
            PC_INC:    pc <= pc_plus4;
            PC_TARGET: pc <= word_align(branch_target);
            PC_PEND:   pc <= redir_tgt;
            default:   pc <= pc;
         endcase
      end
   end

   // Parked redirect: the newest target overwrites any older one
   always_ff @(posedge clk) begin
      if (reset) begin
         redir_tgt  <= 32'h0000_0000;
         redir_pend <= 1'b0;
      end else if (latch_redir) begin
         redir_tgt  <= word_align(branch_target);
         redir_pend <= 1'b1;
      end else if (clr_pend) begin
         redir_tgt  <= redir_tgt;
         redir_pend <= 1'b0;
      end else begin
         redir_tgt  <= redir_tgt;
         redir_pend <= redir_pend;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: miss FSM, redirect handling and the fetch/decode register.
module fetch_stage
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          EN_REG,
   input  logic          branch_taken,
   input  logic [31:0]   branch_target,
   fetch_stage_if.master icache,
   output logic [31:0]   instruction,
   output logic [31:0]   PCNEXT,
   output logic          instr_valid,
   output logic          flush,
   output logic          block_pipe_instr_cache
);

   fetch_state_t state;
   fetch_state_t state_next;
   pc_sel_t      pc_sel;
   out_sel_t     out_sel;
   logic         flush_next;
   logic         latch_redir;
   logic         clr_pend;
   logic [31:0]  pc;
   logic [31:0]  pc_plus4;
   logic         redir_pend;

   pc_unit #(.RESET_PC(RESET_PC)) u_pc_unit (
      .clk           (clk),
      .reset         (reset),
      .pc_sel        (pc_sel),
      .branch_target (branch_target),
      .latch_redir   (latch_redir),
      .clr_pend      (clr_pend),
      .pc            (pc),
      .pc_plus4      (pc_plus4),
      .redir_pend    (redir_pend)
   );

   // Lookup is issued only while not waiting on a fill; stall is seen in the detect cycle
   assign icache.icache_req     = (state == FETCH);
   assign icache.icache_addr    = pc;
   assign block_pipe_instr_cache = ((state == FETCH) && !icache.icache_hit) || (state == MISS_WAIT);

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= FETCH;
      end else begin
         state <= state_next;
      end
   end

   // Next state and datapath control; redirect outranks the EN_REG hold
   always_comb begin
      state_next  = state;
      pc_sel      = PC_HOLD;
      out_sel     = OUT_HOLD;
      flush_next  = 1'b0;
      latch_redir = 1'b0;
      clr_pend    = 1'b0;
      case (state)
         FETCH: begin
            if (branch_taken) begin
               // Wrong-path lookup of this cycle is discarded
               pc_sel     = PC_TARGET;
               out_sel    = OUT_BUBBLE;
               flush_next = 1'b1;
            end else if (!icache.icache_hit) begin
               state_next = MISS_WAIT;
               out_sel    = EN_REG ? OUT_BUBBLE : OUT_HOLD;
            end else if (EN_REG) begin
               pc_sel  = PC_INC;
               out_sel = OUT_LOAD;
            end else begin
               pc_sel  = PC_HOLD;
               out_sel = OUT_HOLD;
            end
         end
         MISS_WAIT: begin
            if (branch_taken) begin
               flush_next = 1'b1;
               out_sel    = OUT_BUBBLE;
               if (icache.icache_fill_done) begin
                  // Redirect coinciding with fill completion is the newest: take it directly
                  pc_sel     = PC_TARGET;
                  clr_pend   = 1'b1;
                  state_next = FETCH;
               end else begin
                  latch_redir = 1'b1;
               end
            end else begin
               out_sel = EN_REG ? OUT_BUBBLE : OUT_HOLD;
               if (icache.icache_fill_done) begin
                  state_next = FETCH;
                  if (redir_pend) begin
                     pc_sel   = PC_PEND;
                     clr_pend = 1'b1;
                  end else begin
                     pc_sel = PC_HOLD;
                  end
               end else begin
                  state_next = MISS_WAIT;
               end
            end
         end
         default: begin
            state_next = FETCH;
         end
      endcase
   end

   // Fetch/decode pipeline register; flush is a one-cycle pulse regardless of EN_REG
   always_ff @(posedge clk) begin
      if (reset) begin
         instruction <= NOP_INSTR;
         PCNEXT      <= 32'h0000_0000;
         instr_valid <= 1'b0;
         flush       <= 1'b0;
      end else begin
         flush <= flush_next;
         case (out_sel)
            OUT_LOAD: begin
               instruction <= icache.icache_data;
               PCNEXT      <= pc_plus4;
               instr_valid <= 1'b1;
            end
            OUT_BUBBLE: begin
               instruction <= NOP_INSTR;
               PCNEXT      <= 32'h0000_0000;
               instr_valid <= 1'b0;
            end
            default: begin
               instruction <= instruction;
               PCNEXT      <= PCNEXT;
               instr_valid <= instr_valid;
            end
         endcase
      end
   end

endmodule
